// File: rtl/config_loader.sv
// Serial configuration loader: feeds words LSB first into the slice config chain.
// Define CFG_LOADER_CRC_EN to add a CRC-8 trailer check (needs WORD_W >= 8).
module config_loader #(
  parameter int WORD_W     = 8,
  parameter int TOTAL_BITS = 137
) (
  input  logic              cclk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cfg_out,
  output logic              cen,
  output logic              busy,
  output logic              done,
  output logic              crc_err
);

  localparam int CW = $clog2(TOTAL_BITS + 1);
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, SHIFT, CHECK, DONE
  } state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [WORD_W-1:0] sh_q;
  logic [BW-1:0]     bl_q;
  logic              in_ready_q;
  logic              cfg_q;
  logic              cen_q;
  logic              busy_q;
  logic              done_q;
  logic [CW-1:0]     rem;
  logic [CW-1:0]     cnt_d;

  assign rem   = CW'(TOTAL_BITS) - cnt_q;
  assign cnt_d = cnt_q + 1'b1;

`ifdef CFG_LOADER_CRC_EN
  logic [7:0] crc_q;
  logic [7:0] crc_d;
  logic       err_q;

  // MSB-first serial CRC-8, poly 0x07, over the bits in emission order
  assign crc_d = {crc_q[6:0], 1'b0}
               ^ ((crc_q[7] ^ cfg_q) ? 8'h07 : 8'h00);
  assign crc_err = err_q;
`else
  assign crc_err = 1'b0;
`endif

  assign in_ready = in_ready_q;
  assign cfg_out  = cfg_q;
  assign cen      = cen_q;
  assign busy     = busy_q;
  assign done     = done_q;

  always_ff @(posedge cclk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      bl_q       <= '0;
      in_ready_q <= 1'b0;
      cfg_q      <= 1'b0;
      cen_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef CFG_LOADER_CRC_EN
      crc_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= LOAD;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
`ifdef CFG_LOADER_CRC_EN
            crc_q      <= '0;
            err_q      <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (in_valid) begin
            state_q    <= SHIFT;
            in_ready_q <= 1'b0;
            cen_q      <= 1'b1;
            cfg_q      <= in_data[0];
            sh_q       <= in_data >> 1;
            // last word may be partial; only the remaining bits go out
            if (32'(rem) >= 32'(WORD_W))
              bl_q <= BW'(WORD_W - 1);
            else
              bl_q <= BW'(rem - 1'b1);
          end
        end
        SHIFT: begin
          cnt_q <= cnt_d;
`ifdef CFG_LOADER_CRC_EN
          crc_q <= crc_d;
`endif
          if (bl_q != '0) begin
            cfg_q <= sh_q[0];
            sh_q  <= sh_q >> 1;
            bl_q  <= bl_q - 1'b1;
          end else begin
            cen_q <= 1'b0;
            cfg_q <= 1'b0;
            if (cnt_d < CW'(TOTAL_BITS)) begin
              state_q    <= LOAD;
              in_ready_q <= 1'b1;
            end else begin
`ifdef CFG_LOADER_CRC_EN
              state_q    <= CHECK;
              in_ready_q <= 1'b1;
`else
              state_q    <= DONE;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
`endif
            end
          end
        end
        CHECK: begin
`ifdef CFG_LOADER_CRC_EN
          if (in_valid) begin
            state_q    <= DONE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            err_q      <= (in_data[7:0] != crc_q);
          end
`else
          state_q <= IDLE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader, TOTAL_BITS=20, WORD_W=8.
// Works with or without CFG_LOADER_CRC_EN defined.
module tb_config_loader;

  logic       cclk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       cfg_out;
  logic       cen;
  logic       busy;
  logic       done;
  logic       crc_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] words [3] = '{8'hA5, 8'h3C, 8'hF9};
  localparam logic [19:0] EXP_BITS = 20'h93CA5;
`ifdef CFG_LOADER_CRC_EN
  localparam int EXP_CYC = 24;
  localparam int EXP_ACC = 4;
`else
  localparam int EXP_CYC = 23;
  localparam int EXP_ACC = 3;
`endif

  config_loader #(.WORD_W(8), .TOTAL_BITS(20)) dut (
    .cclk     (cclk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cfg_out  (cfg_out),
    .cen      (cen),
    .busy     (busy),
    .done     (done),
    .crc_err  (crc_err)
  );

  always #5 cclk = ~cclk;

  task automatic step();
    @(posedge cclk);
    #1;
  endtask

  function automatic logic [7:0] crc_ref(input logic [19:0] b);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < 20; i++) begin
      fb = c[7] ^ b[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic run_load(
    input  bit         do_start,
    input  int         start_at,
    input  int         rst_at,
    input  logic [7:0] tx,
    output int         ncen,
    output logic [19:0] bits,
    output int         cyc,
    output int         nacc,
    output int         bad,
    output bit         ok
  );
    ncen = 0; bits = '0; cyc = 0;
    nacc = 0; bad = 0; ok = 1'b0;
    if (do_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    for (int c = 0; c < 80; c++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      cyc++;
      if (!cen && cfg_out) bad++;
      if (cen) begin
        if (ncen < 20) bits[ncen] = cfg_out;
        ncen++;
      end
      if (rst_at >= 0 && cen && ncen == rst_at + 1) begin
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        break;
      end
      start = (start_at >= 0 && cen && ncen == start_at + 1);
      if (in_ready) begin
        in_valid = 1'b1;
        in_data  = (nacc < 3) ? words[nacc] : (crc_ref(EXP_BITS) ^ tx);
        nacc++;
      end else begin
        in_valid = 1'b0;
        in_data  = '0;
      end
      step();
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    in_valid = 1'b0; in_data = '0;
    step();
    step();
    checks++;
    if ({in_ready, cfg_out, cen, busy, done, crc_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outs: got %b expected 000000",
               {in_ready, cfg_out, cen, busy, done, crc_err});
    end
    rst = 1'b0;
    step();
    checks++;
    if ({in_ready, busy, done} !== 3'b0) begin
      failures++;
      $display("FAIL idle_hold: got %b expected 000", {in_ready, busy, done});
    end
  endtask

  task automatic test_basic();
    int n, cy, na, bd;
    logic [19:0] b;
    bit ok;
    run_load(1'b1, -1, -1, 8'h00, n, b, cy, na, bd, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL basic_timeout: done not seen within budget");
    end
    checks++;
    if (n !== 20) begin
      failures++;
      $display("FAIL basic_ncen: got %0d expected 20", n);
    end
    checks++;
    if (b !== EXP_BITS) begin
      failures++;
      $display("FAIL basic_bits: got %h expected %h", b, EXP_BITS);
    end
    checks++;
    if (cy !== EXP_CYC) begin
      failures++;
      $display("FAIL basic_cycles: got %0d expected %0d", cy, EXP_CYC);
    end
    checks++;
    if (na !== EXP_ACC) begin
      failures++;
      $display("FAIL basic_words: got %0d expected %0d", na, EXP_ACC);
    end
    checks++;
    if (bd !== 0) begin
      failures++;
      $display("FAIL basic_cfg_idle: got %0d expected 0", bd);
    end
    checks++;
    if ({busy, done, in_ready, cen, crc_err} !== 5'b01000) begin
      failures++;
      $display("FAIL basic_final: got %b expected 01000",
               {busy, done, in_ready, cen, crc_err});
    end
    step(); step(); step();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL done_hold: got %b expected 1", done);
    end
  endtask

  task automatic test_crc_bad();
    int n, cy, na, bd;
    logic [19:0] b;
    bit ok;
    logic exp_err;
`ifdef CFG_LOADER_CRC_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    run_load(1'b1, -1, -1, 8'h01, n, b, cy, na, bd, ok);
    checks++;
    if (!ok || n !== 20) begin
      failures++;
      $display("FAIL crcbad_run: ok=%0d ncen=%0d expected ok=1 ncen=20", ok, n);
    end
    checks++;
    if ({done, crc_err} !== {1'b1, exp_err}) begin
      failures++;
      $display("FAIL crcbad_err: got done=%b err=%b expected done=1 err=%b",
               done, crc_err, exp_err);
    end
    checks++;
    if (na !== EXP_ACC) begin
      failures++;
      $display("FAIL crcbad_words: got %0d expected %0d", na, EXP_ACC);
    end
  endtask

  task automatic test_stall();
    int n, cy, na, bd;
    logic [19:0] b;
    bit ok;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({in_ready, busy, done, crc_err} !== 4'b1100) begin
      failures++;
      $display("FAIL restart: got %b expected 1100",
               {in_ready, busy, done, crc_err});
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b0;
      step();
      checks++;
      if ({in_ready, cen, busy, cfg_out} !== 4'b1010) begin
        failures++;
        $display("FAIL stall_%0d: got %b expected 1010",
                 i, {in_ready, cen, busy, cfg_out});
      end
    end
    run_load(1'b0, -1, -1, 8'h00, n, b, cy, na, bd, ok);
    checks++;
    if (!ok || n !== 20 || b !== EXP_BITS) begin
      failures++;
      $display("FAIL stall_finish: ok=%0d ncen=%0d bits=%h expected 1 20 %h",
               ok, n, b, EXP_BITS);
    end
  endtask

  task automatic test_start_in_shift();
    int n, cy, na, bd;
    logic [19:0] b;
    bit ok;
    run_load(1'b1, 5, -1, 8'h00, n, b, cy, na, bd, ok);
    checks++;
    if (!ok || n !== 20 || cy !== EXP_CYC) begin
      failures++;
      $display("FAIL start_ignored: ok=%0d ncen=%0d cyc=%0d expected 1 20 %0d",
               ok, n, cy, EXP_CYC);
    end
    checks++;
    if (b !== EXP_BITS) begin
      failures++;
      $display("FAIL start_ignored_bits: got %h expected %h", b, EXP_BITS);
    end
  endtask

  task automatic test_reset_mid();
    int n, cy, na, bd;
    logic [19:0] b;
    bit ok;
    run_load(1'b1, -1, 11, 8'h00, n, b, cy, na, bd, ok);
    checks++;
    if (n !== 12 || ok) begin
      failures++;
      $display("FAIL rstmid_point: ncen=%0d ok=%0d expected 12 0", n, ok);
    end
    checks++;
    if ({cen, busy, done, in_ready, cfg_out} !== 5'b0) begin
      failures++;
      $display("FAIL rstmid_outs: got %b expected 00000",
               {cen, busy, done, in_ready, cfg_out});
    end
    step();
    checks++;
    if ({cen, busy, done} !== 3'b0) begin
      failures++;
      $display("FAIL rstmid_idle: got %b expected 000", {cen, busy, done});
    end
    run_load(1'b1, -1, -1, 8'h00, n, b, cy, na, bd, ok);
    checks++;
    if (!ok || n !== 20 || b !== EXP_BITS || cy !== EXP_CYC) begin
      failures++;
      $display("FAIL rstmid_reload: ok=%0d ncen=%0d bits=%h cyc=%0d expected 1 20 %h %0d",
               ok, n, b, cy, EXP_BITS, EXP_CYC);
    end
    checks++;
    if (crc_err !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_crc: got %b expected 0", crc_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_crc_bad();
    test_stall();
    test_start_in_shift();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 The module SHALL have one clock and one synchronous, active-high reset; all state SHALL change only on the rising edge of cclk.
REQ-002 Parameter WORD_W, default 8, SHALL set the width of input configuration words.
REQ-003 Parameter TOTAL_BITS, default 137, SHALL set the configuration chain length in bits (4 LUTs x 2 x 17, plus 1 carry-select bit).
REQ-004 cclk  input  1  configuration clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a load.
REQ-007 in_data  input  WORD_W  bitstream word.
REQ-008 in_valid  input  1  in_data is valid.
REQ-009 in_ready  output  1  loader accepts a word this cycle.
REQ-010 cfg_out  output  1  serial configuration bit to the slice config_in chain.
REQ-011 cen  output  1  configuration enable to the slice; a bit shifts on each cclk edge where cen=1.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  all TOTAL_BITS have been shifted.
REQ-014 crc_err  output  1  trailer CRC mismatch.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, SHIFT, CHECK and DONE.
REQ-016 IDLE or DONE with start=1 SHALL go to LOAD, clear the bit counter and CRC, and clear done and crc_err.
REQ-017 start in LOAD, SHIFT or CHECK SHALL be ignored.
REQ-018 in_ready SHALL be 1 only in LOAD and CHECK; a word is accepted on an edge where in_valid&in_ready.
REQ-019 LOAD SHALL capture the accepted word and go to SHIFT on the next cycle; LOAD SHALL wait indefinitely without valid.
REQ-020 SHIFT SHALL emit the captured word LSB first, one bit per cycle, with cfg_out and cen both registered and cycle-aligned.
REQ-021 SHIFT SHALL emit min(WORD_W, TOTAL_BITS - count) bits; the unused upper bits of the final word SHALL be discarded and SHALL never be driven with cen=1.
REQ-022 After each word, SHIFT SHALL return to LOAD if count < TOTAL_BITS, otherwise go to CHECK (CRC build) or DONE.
REQ-023 cen SHALL be 0 in every state except SHIFT; cfg_out SHALL be 0 whenever cen=0.
REQ-024 Exactly TOTAL_BITS cycles with cen=1 SHALL occur per load; the first bit emitted ends farthest down the chain.
REQ-025 The bit counter SHALL be $clog2(TOTAL_BITS+1) bits wide and SHALL never exceed TOTAL_BITS.
REQ-026 busy SHALL be 1 in LOAD, SHIFT and CHECK.
REQ-027 done SHALL be 1 in DONE and held until the next start or rst.

Reset
REQ-028 rst=1 SHALL, at the next edge, force IDLE, count=0, crc=0, and in_ready, cfg_out, cen, busy, done and crc_err all to 0.
REQ-029 rst asserted mid-load SHALL abort the load; cen SHALL be 0 from the following cycle, and no partial done SHALL be reported.

Configuration
REQ-030 The macro CFG_LOADER_CRC_EN SHALL enable CRC checking.
REQ-031 With CFG_LOADER_CRC_EN defined, a CRC-8 (polynomial 0x07, init 0x00) SHALL be updated with each bit emitted with cen=1.
REQ-032 With CFG_LOADER_CRC_EN defined, CHECK SHALL accept one trailer word, compare its low 8 bits to the CRC, set crc_err=1 on mismatch, and go to DONE.
REQ-033 Without CFG_LOADER_CRC_EN, CHECK SHALL be unreachable, SHIFT SHALL go directly to DONE, and crc_err SHALL be tied to 0.

Verification
REQ-034 Reset, then start with TOTAL_BITS=20, WORD_W=8, and words 0xA5, 0x3C, 0xF9 sent back-to-back -> 20 cen cycles, cfg_out = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,0,0,1; done=1 after 23 data cycles.
REQ-035 in_valid held low for 5 cycles in LOAD -> in_ready stays 1, cen stays 0, and there is no count change.
REQ-036 rst pulsed during the 4th shift cycle of word 2 -> cen=0, busy=0 and done=0 on the next cycle; a fresh start then completes normally.
REQ-037 start pulsed during SHIFT -> ignored; the cen cycle total is still exactly 20.
REQ-038 With CFG_LOADER_CRC_EN, a correct trailer gives crc_err=0; trailer XOR 0x01 gives crc_err=1 and done=1.
REQ-039 Without CFG_LOADER_CRC_EN, the same stimulus gives done right after the last shift, no trailer accepted, and crc_err=0.
